// File: rtl/icache_data_sram_ctrl.sv
// I-cache data SRAM controller: arbitrates fetch line reads and refill beats
// onto a 1RW macro and holds read data behind a valid/ready response.
module icache_data_sram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 128,
  parameter int BEAT_WIDTH = 64,
  localparam int NUM_WMASKS = DATA_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_index,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  flush,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [ADDR_WIDTH-1:0] refill_index,
  input  logic [BEAT_WIDTH-1:0] refill_data,
  input  logic                  refill_last,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int BCW = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_RSP, WR_ISSUE
  } state_e;

  state_e                state_q, state_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  drop_q, drop_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    idx_d        = idx_q;
    drop_d       = drop_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    wmask_d      = '0;
    addr_d       = addr_q;
    din_d        = din_q;
    req_ready    = 1'b0;
    refill_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        refill_ready = 1'b1;
        req_ready    = ~refill_valid & ~flush;
        if (refill_valid) begin
          state_d = WR_ISSUE;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          din_d   = {NUM_WMASKS{refill_data}};
          wmask_d = NUM_WMASKS'(1) << beat_cnt_q;
          if (beat_cnt_q == '0) begin
            addr_d = refill_index;
            idx_d  = refill_index;
          end else begin
            addr_d = idx_q;
          end
          beat_cnt_d = refill_last ? '0 : beat_cnt_q + BCW'(1);
        end else if (req_valid && !flush) begin
          state_d = RD_ISSUE;
          csb_d   = 1'b0;
          addr_d  = req_index;
        end
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: begin
        if (flush) drop_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_data_d = sram_dout;
        if (drop_q || flush) begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RD_RSP;
        end
      end
      RD_RSP: begin
        if (rsp_ready || flush) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_aL) begin
      req_ready    = 1'b0;
      refill_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      idx_q       <= '0;
      drop_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      // last on the first beat leaves the line half written
      assert (!(state_q == IDLE && refill_valid &&
                refill_last && beat_cnt_q == '0));
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      idx_q       <= idx_d;
      drop_q      <= drop_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

endmodule

// File: tb/tb_icache_data_sram_ctrl.sv
// Bench for icache_data_sram_ctrl: behavioural SRAM macro plus a line-level
// memory model; directed corner cases followed by random reads/refills.
module tb_icache_data_sram_ctrl;
  localparam int AW = 6;
  localparam int DW = 128;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst_aL;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_index;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          flush;
  logic          refill_valid, refill_ready;
  logic [AW-1:0] refill_index;
  logic [BW-1:0] refill_data;
  logic          refill_last;
  logic          sram_csb, sram_web;
  logic [1:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  always #5 clk = ~clk;

  icache_data_sram_ctrl dut (
    .clk(clk), .rst_aL(rst_aL),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flush(flush),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_index(refill_index), .refill_data(refill_data),
    .refill_last(refill_last),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // macro: pins sampled at posedge, array accessed at negedge
  logic [DW-1:0] arr [64];
  logic          s_csb = 1'b1, s_web = 1'b1;
  logic [1:0]    s_mask = '0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_din = '0;

  always @(posedge clk) begin
    if (!rst_aL) begin
      for (int i = 0; i < 64; i++) arr[i] <= '0;
      s_csb <= 1'b1;
    end else begin
      s_csb  <= sram_csb;
      s_web  <= sram_web;
      s_mask <= sram_wmask;
      s_addr <= sram_addr;
      s_din  <= sram_din;
    end
  end

  always @(negedge clk) begin
    if (!s_csb) begin
      if (!s_web) begin
        if (s_mask[0]) arr[s_addr][63:0]   <= s_din[63:0];
        if (s_mask[1]) arr[s_addr][127:64] <= s_din[127:64];
      end else begin
        sram_dout <= arr[s_addr];
      end
    end
  end

  logic [DW-1:0] mem_m [64];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit is_refill);
    int n = 0;
    #1;
    while (!(is_refill ? refill_ready : req_ready) && n < 16) begin
      tick;
      n++;
    end
    if (n == 16) chk("ready_timeout", DW'(0), DW'(1));
  endtask

  task automatic beat(input logic [AW-1:0] idx, input logic [BW-1:0] d,
                      input bit last, input logic [AW-1:0] ea,
                      input logic [1:0] em);
    refill_valid = 1'b1;
    refill_index = idx;
    refill_data  = d;
    refill_last  = last;
    wait_rdy(1'b1);
    tick;
    refill_valid = 1'b0;
    refill_last  = 1'b0;
    #1;
    chk("wr_csb", DW'(sram_csb), DW'(0));
    chk("wr_web", DW'(sram_web), DW'(0));
    chk("wr_mask", DW'(sram_wmask), DW'(em));
    chk("wr_addr", DW'(sram_addr), DW'(ea));
    chk("wr_din", sram_din, {d, d});
    chk("wr_busy", DW'(refill_ready), DW'(0));
    tick;
    chk("wr_csb_hi", DW'(sram_csb), DW'(1));
  endtask

  // beat 1 carries a scrambled index to show only beat 0's index counts
  task automatic refill_line(input logic [AW-1:0] idx,
                             input logic [BW-1:0] d0,
                             input logic [BW-1:0] d1);
    beat(idx, d0, 1'b0, idx, 2'b01);
    beat(~idx, d1, 1'b1, idx, 2'b10);
    mem_m[idx] = {d1, d0};
  endtask

  // fl: 0 none, 1 flush in RD_ISSUE, 2 in RD_WAIT, 3 while response held
  task automatic read_tail(input logic [AW-1:0] idx, input int stall,
                           input int fl);
    logic [DW-1:0] exp;
    exp = mem_m[idx];
    chk("rd_csb", DW'(sram_csb), DW'(0));
    chk("rd_web", DW'(sram_web), DW'(1));
    chk("rd_addr", DW'(sram_addr), DW'(idx));
    if (fl == 1) flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("rd_lat1", DW'(rsp_valid), DW'(0));
    if (fl == 2) flush = 1'b1;
    tick;
    flush = 1'b0;
    if (fl == 1 || fl == 2) begin
      chk("drop_v", DW'(rsp_valid), DW'(0));
      tick;
      chk("drop_v2", DW'(rsp_valid), DW'(0));
    end else begin
      chk("rsp_v", DW'(rsp_valid), DW'(1));
      chk("rsp_d", rsp_data, exp);
      if (fl == 3) begin
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_rsp", DW'(rsp_valid), DW'(0));
      end else begin
        for (int i = 0; i < stall; i++) begin
          tick;
          chk("hold_v", DW'(rsp_valid), DW'(1));
          chk("hold_d", rsp_data, exp);
          chk("hold_rdy", DW'(req_ready), DW'(0));
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_done", DW'(rsp_valid), DW'(0));
      end
    end
  endtask

  task automatic read(input logic [AW-1:0] idx, input int stall,
                      input int fl);
    req_valid = 1'b1;
    req_index = idx;
    wait_rdy(1'b0);
    tick;
    req_valid = 1'b0;
    read_tail(idx, stall, fl);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] d0, d1;
    logic [AW-1:0] ri;
    int fl;
    rst_aL = 1'b0;
    req_valid = 1'b1; req_index = '0; rsp_ready = 1'b0; flush = 1'b0;
    refill_valid = 1'b1; refill_index = '0; refill_data = '0;
    refill_last = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    tick;
    tick;
    chk("rst_csb", DW'(sram_csb), DW'(1));
    chk("rst_web", DW'(sram_web), DW'(1));
    chk("rst_mask", DW'(sram_wmask), DW'(0));
    chk("rst_addr", DW'(sram_addr), DW'(0));
    chk("rst_din", sram_din, DW'(0));
    chk("rst_rspv", DW'(rsp_valid), DW'(0));
    chk("rst_rspd", rsp_data, DW'(0));
    chk("rst_req_rdy", DW'(req_ready), DW'(0));
    chk("rst_ref_rdy", DW'(refill_ready), DW'(0));
    req_valid = 1'b0;
    refill_valid = 1'b0;
    rst_aL = 1'b1;
    #1;
    chk("rel_req_rdy", DW'(req_ready), DW'(1));
    chk("rel_ref_rdy", DW'(refill_ready), DW'(1));

    refill_line(6'd5, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("line5_model", mem_m[5],
        128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA);
    read(6'd5, 0, 0);

    // refill and read together: refill wins, read two cycles later
    d0 = 64'h1111_2222_3333_4444;
    d1 = 64'h5555_6666_7777_8888;
    refill_valid = 1'b1; refill_index = 6'd7; refill_data = d0;
    req_valid = 1'b1; req_index = 6'd5;
    #1;
    chk("col_req_rdy", DW'(req_ready), DW'(0));
    chk("col_ref_rdy", DW'(refill_ready), DW'(1));
    tick;
    refill_valid = 1'b0;
    chk("col_wr_csb", DW'(sram_csb), DW'(0));
    chk("col_wr_web", DW'(sram_web), DW'(0));
    chk("col_wr_mask", DW'(sram_wmask), DW'(1));
    chk("col_wr_addr", DW'(sram_addr), DW'(7));
    tick;
    chk("col_rd_rdy", DW'(req_ready), DW'(1));
    tick;
    req_valid = 1'b0;
    read_tail(6'd5, 0, 0);
    beat(6'd40, d1, 1'b1, 6'd7, 2'b10);
    mem_m[7] = {d1, d0};
    read(6'd7, 0, 0);

    read(6'd5, 4, 0);

    // flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_index = 6'd5;
    #1;
    chk("idle_flush_rdy", DW'(req_ready), DW'(0));
    tick;
    chk("idle_flush_csb", DW'(sram_csb), DW'(1));
    flush = 1'b0;
    req_valid = 1'b0;

    read(6'd5, 0, 2);
    read(6'd0, 0, 0);
    read(6'd5, 0, 1);
    read(6'd5, 0, 3);
    read(6'd7, 1, 0);

    for (int it = 0; it < 60; it++) begin
      ri = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        refill_line(ri, d0, d1);
      end else begin
        fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        read(ri, int'($urandom_range(0, 3)), fl);
      end
    end

    // reset during a write: beat lost, counter cleared, array cleared
    refill_valid = 1'b1; refill_index = 6'd9;
    refill_data = 64'hDEAD_BEEF_DEAD_BEEF; refill_last = 1'b0;
    wait_rdy(1'b1);
    tick;
    refill_valid = 1'b0;
    rst_aL = 1'b0;
    tick;
    rst_aL = 1'b1;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    chk("rstwr_csb", DW'(sram_csb), DW'(1));
    beat(6'd12, 64'h0123_4567_89AB_CDEF, 1'b0, 6'd12, 2'b01);
    beat(6'd13, 64'hFEDC_BA98_7654_3210, 1'b1, 6'd12, 2'b10);
    mem_m[12] = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    read(6'd5, 0, 0);
    read(6'd9, 0, 0);
    read(6'd12, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
